writeback_sequencer: RTL
========================

Name: writeback_sequencer

Overview:
- Write-back side of the register file: accepts results from the ALU/memory path, buffers them in a small in-order FIFO, and issues one register write per cycle using a valid/ready handshake.
- Converts the instruction opcode into byte-enable masks (LBU 0x24 / LHU 0x25 partial writes).
- Exports a scoreboard so the read side can detect RAW hazards on rs/rt against writes that are still pending.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- PTR_W, 2, log2(DEPTH); occupancy counter is PTR_W+1 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents a result.
- in_ready  output  1  FIFO can accept (= !full).
- in_data  input  32  result value.
- in_dest  input  5  destination register (already resolved rd/rt per RegDst).
- in_opcode  input  6  instruction opcode.
- in_regwrite  input  1  result must be written.
- rf_write_en  output  1  write request valid (head of FIFO).
- rf_ready  input  1  register file accepts the write this cycle.
- rf_write_addr  output  5  destination register.
- rf_write_data  output  32  data, with unused bytes zeroed.
- rf_write_mask  output  4  byte enables; bit0 = data[7:0].
- q_rs, q_rt  input  5 each  scoreboard query addresses.
- busy_rs, busy_rt  output  1 each  query address has a pending write.
- count  output  PTR_W+1  current occupancy.

Behaviour:
- Reset: rd/wr pointers = 0, count = 0, all entry valid bits = 0.
  - Outputs after reset: rf_write_en = 0, rf_write_addr = 0, rf_write_data = 0, rf_write_mask = 0, busy_* = 0, in_ready = 1.
  - Reset mid-operation discards every queued entry with no write issued; reset has priority over push/pop in the same cycle.
- Push: on a clk edge with in_valid & in_ready.
  - If in_regwrite = 0 or in_dest = 0, the transaction is accepted (handshake completes) but nothing is enqueued.
  - Otherwise the entry {dest, data', mask} is written at wr_ptr and wr_ptr advances, wrapping modulo DEPTH.
- Mask and data derivation at push:
  - opcode 0x24: mask 4'b0001, data' = {24'b0, in_data[7:0]}.
  - opcode 0x25: mask 4'b0011, data' = {16'b0, in_data[15:0]}.
  - Any other opcode: mask 4'b1111, data' = in_data.
- Output:
  - rf_write_en = (count != 0).
  - rf_write_addr, rf_write_data and rf_write_mask come from the entry at rd_ptr, driven from registered storage.
  - All three must hold stable while rf_write_en & !rf_ready.
- Pop: on a clk edge with rf_write_en & rf_ready, rd_ptr advances (wrapping) and the entry is invalidated.
- Latency: an entry pushed into an empty FIFO appears on rf_write_en in the cycle after the accepting edge. One write can retire per cycle.
- Simultaneous push and pop:
  - count is unchanged.
  - When the FIFO is full, in_ready = 0, so no push occurs even if a pop occurs in that cycle; in_ready rises the cycle after the pop.
  - When the FIFO is empty, a push and the following pop never overlap (no bypass).
- count: +1 on an enqueue only, −1 on a pop only. It never exceeds DEPTH and never goes below 0.
- Scoreboard:
  - busy_x = (q_x != 0) & (any valid entry has dest == q_x).
  - Combinational from the registered entry state.
  - An entry being popped this cycle still reports busy until the edge.
  - Multiple pending writes to the same register keep busy asserted until the last one pops.
- Ordering: writes are issued strictly in acceptance order. Duplicate destinations are not merged.

Test Plan:
- rst for 2 cycles then release → rf_write_en = 0, count = 0, in_ready = 1, busy_rs = busy_rt = 0.
- Push {dest=5, opcode=0x23, data=0xDEADBEEF, regwrite=1} with rf_ready = 1 → next cycle rf_write_en = 1, addr = 5, data = 0xDEADBEEF, mask = 4'b1111; the cycle after, rf_write_en = 0.
- Push dest=7, opcode=0x24, data=0x12345678 → data = 0x00000078, mask = 4'b0001.
- Push dest=8, opcode=0x25, same data → data = 0x00005678, mask = 4'b0011.
- rf_ready = 0, push 4 entries (dest=1..4) → count = 4, in_ready = 0, a 5th in_valid is not accepted, and addr holds 1 steadily.
  - Then rf_ready = 1 → writes retire in order 1, 2, 3, 4, one per cycle; in_ready rises the cycle after the first pop.
- Push dest=0 or regwrite=0 → handshake completes, count stays 0, no write issued.
- Two pending writes to r9, q_rs = 9 → busy_rs = 1 until the second pops; q_rs = 0 → busy_rs = 0.
- Assert rst with 3 entries queued → next cycle count = 0, rf_write_en = 0, busy_* = 0, and no write was issued.

Source files
------------

// File: rtl/writeback_sequencer.sv
// Write-back sequencer: in-order result FIFO feeding one register-file write per
// cycle over valid/ready, with byte-enable derivation and a pending-write scoreboard.
module writeback_sequencer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [4:0]       in_dest,
    input  logic [5:0]       in_opcode,
    input  logic             in_regwrite,
    output logic             rf_write_en,
    input  logic             rf_ready,
    output logic [4:0]       rf_write_addr,
    output logic [31:0]      rf_write_data,
    output logic [3:0]       rf_write_mask,
    input  logic [4:0]       q_rs,
    input  logic [4:0]       q_rt,
    output logic             busy_rs,
    output logic             busy_rt,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0] CNT_ONE    = (PTR_W + 1)'(1);

    function automatic logic [3:0] derive_mask(input logic [5:0] op);
        case (op)
            6'h24:   return 4'b0001;
            6'h25:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] derive_data(input logic [5:0] op, input logic [31:0] d);
        case (op)
            6'h24:   return {24'h000000, d[7:0]};
            6'h25:   return {16'h0000, d[15:0]};
            default: return d;
        endcase
    endfunction

    logic [4:0]       dest_r [DEPTH];
    logic [31:0]      data_r [DEPTH];
    logic [3:0]       mask_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    logic accept_s;
    logic enq_s;
    logic pop_s;
    logic busy_rs_s;
    logic busy_rt_s;

    // Handshake decode; dropped results (no regwrite or r0) still complete the handshake.
    always_comb begin
        in_ready    = (count_r != FULL_COUNT);
        rf_write_en = (count_r != {(PTR_W + 1){1'b0}});
        accept_s    = in_valid & in_ready;
        enq_s       = accept_s & in_regwrite & (in_dest != 5'd0);
        pop_s       = rf_write_en & rf_ready;
    end

    // Head-of-queue outputs read straight from storage; popped slots are zeroed so an empty queue shows zeros.
    always_comb begin
        rf_write_addr = dest_r[rd_ptr_r];
        rf_write_data = data_r[rd_ptr_r];
        rf_write_mask = mask_r[rd_ptr_r];
        count         = count_r;
    end

    // Scoreboard: any valid entry whose destination matches the query; r0 is never busy.
    always_comb begin
        busy_rs_s = 1'b0;
        busy_rt_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_rs_s = busy_rs_s | (valid_r[i] & (dest_r[i] == q_rs));
            busy_rt_s = busy_rt_s | (valid_r[i] & (dest_r[i] == q_rt));
        end
        busy_rs = busy_rs_s & (q_rs != 5'd0);
        busy_rt = busy_rt_s & (q_rt != 5'd0);
    end

    // FIFO storage, pointers and occupancy; reset overrides any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_r[i] <= 5'd0;
                data_r[i] <= 32'd0;
                mask_r[i] <= 4'd0;
            end
        end else begin
            // Push and pop never target the same slot: equal pointers mean empty (no pop) or full (no push).
            if (enq_s) begin
                dest_r[wr_ptr_r]  <= in_dest;
                data_r[wr_ptr_r]  <= derive_data(in_opcode, in_data);
                mask_r[wr_ptr_r]  <= derive_mask(in_opcode);
                valid_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r          <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                dest_r[rd_ptr_r]  <= 5'd0;
                data_r[rd_ptr_r]  <= 32'd0;
                mask_r[rd_ptr_r]  <= 4'd0;
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PTR_ONE;
            end
            case ({enq_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
